stopwatch_bcd4: RTL and testbench

// - Stopwatch core: 4-digit BCD elapsed-time counter, upstream of the 7-seg multiplexing display stage.
// - Owns the timebase prescaler, start/stop and clear button handling, and BCD ripple/wrap.
// - Presents four packed BCD digits plus status; the display stage converts and scans them.

---
 rtl/stopwatch_bcd4_pkg.sv | 32 +++
 rtl/stopwatch_bcd4_button_debounce.sv | 42 ++++
 rtl/stopwatch_bcd4.sv | 137 +++++++++++++
 tb/tb_stopwatch_bcd4.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_bcd4_pkg.sv
// Shared types and helpers for the stopwatch_bcd4 core.
// State encodings and the 4-digit BCD increment used by the count chain.
package stopwatch_bcd4_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Returns {carry_out, next}; a digit at or above 9 rolls to 0 and carries.
    function automatic logic [16:0] bcd4_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (v[i*4 +: 4] >= BCD_MAX) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return {c, r};
    endfunction

endpackage

// File: rtl/stopwatch_bcd4_button_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter, press pulse.
// Emits one pulse per accepted rising level; releases are silent.
module stopwatch_bcd4_button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    r_sync;
    logic          r_level;
    logic [CW-1:0] r_cnt;
    logic          r_press;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync  <= 2'b00;
            r_level <= 1'b0;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_btn};
            r_press <= 1'b0;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
                r_press <= r_sync[1];
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/stopwatch_bcd4.sv
// Stopwatch core: prescaler, start/stop/clear FSM, 4-digit BCD count.
// Define STOPWATCH_LAP_EN to add the btn_lap port and lap hold register.
module stopwatch_bcd4 #(
    parameter int CLK_HZ          = 50000000,
    parameter int TICK_HZ         = 10,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        btn_start_stop,
    input  logic        btn_clear,
`ifdef STOPWATCH_LAP_EN
    input  logic        btn_lap,
`endif
    output logic [15:0] digits,
    output logic        running,
    output logic        tick,
    output logic        overflow
);

    import stopwatch_bcd4_pkg::*;

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    state_t        r_state;
    state_t        w_next;
    logic [PW-1:0] r_presc;
    logic [15:0]   r_count;
    logic [16:0]   w_inc;
    logic          w_ss;
    logic          w_clr;
    logic          w_tick;

    stopwatch_bcd4_button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_ss (
        .i_clk  (clock),
        .i_rst  (reset),
        .i_btn  (btn_start_stop),
        .o_press(w_ss)
    );

    stopwatch_bcd4_button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_clr (
        .i_clk  (clock),
        .i_rst  (reset),
        .i_btn  (btn_clear),
        .o_press(w_clr)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // In PAUSE clear beats start_stop; in RUN only start_stop matters.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_ss) w_next = ST_RUN;
            ST_RUN:   if (w_ss) w_next = ST_PAUSE;
            ST_PAUSE: begin
                if (w_clr) begin
                    w_next = ST_IDLE;
                end else if (w_ss) begin
                    w_next = ST_RUN;
                end
            end
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        running = (r_state == ST_RUN);
    end

    assign w_tick   = (r_state == ST_RUN) && (r_presc == PW'(DIV - 1));
    assign w_inc    = bcd4_inc(r_count);
    assign tick     = w_tick;
    assign overflow = w_tick && w_inc[16];

    // Prescaler only advances in RUN, so PAUSE keeps the partial interval.
    always_ff @(posedge clock) begin
        if (reset || (w_next == ST_IDLE)) begin
            r_presc <= '0;
            r_count <= 16'h0000;
        end else if (r_state == ST_RUN) begin
            if (w_tick) begin
                r_presc <= '0;
                r_count <= w_inc[15:0];
            end else begin
                r_presc <= r_presc + PW'(1);
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic        w_lap;
    logic        r_lap_on;
    logic [15:0] r_hold;

    stopwatch_bcd4_button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_lap (
        .i_clk  (clock),
        .i_rst  (reset),
        .i_btn  (btn_lap),
        .o_press(w_lap)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_lap_on <= 1'b0;
            r_hold   <= 16'h0000;
        end else if (w_next != r_state) begin
            r_lap_on <= 1'b0;
        end else if ((r_state == ST_RUN) && w_lap) begin
            if (r_lap_on) begin
                r_lap_on <= 1'b0;
            end else begin
                r_lap_on <= 1'b1;
                r_hold   <= r_count;
            end
        end
    end

    assign digits = r_lap_on ? r_hold : r_count;
`else
    assign digits = r_count;
`endif

endmodule

// File: tb/tb_stopwatch_bcd4.sv
// Self-checking bench for stopwatch_bcd4 (DIV=10, debounce 4).
// Lap checks are included when STOPWATCH_LAP_EN is defined.
module tb_stopwatch_bcd4;

    localparam int DIV = 10;
    localparam int DB  = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        b_ss  = 1'b0;
    logic        b_clr = 1'b0;
    logic        b_lap = 1'b0;
    logic [15:0] digits;
    logic        running, tick, overflow;

    logic        x_ss  = 1'b0;
    logic        x_clr = 1'b0;
    logic        x_lap = 1'b0;
    logic [15:0] x_digits;
    logic        x_running, x_tick, x_overflow;

    int errs   = 0;
    int checks = 0;

    always #5 clock = ~clock;

    stopwatch_bcd4 #(
        .CLK_HZ(100), .TICK_HZ(10), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .btn_start_stop(b_ss),
        .btn_clear     (b_clr),
`ifdef STOPWATCH_LAP_EN
        .btn_lap       (b_lap),
`endif
        .digits        (digits),
        .running       (running),
        .tick          (tick),
        .overflow      (overflow)
    );

    // Second instance with DIV=1 so the 9999 wrap is reachable quickly.
    stopwatch_bcd4 #(
        .CLK_HZ(10), .TICK_HZ(10), .DEBOUNCE_CYCLES(DB)
    ) dut_wrap (
        .clock         (clock),
        .reset         (reset),
        .btn_start_stop(x_ss),
        .btn_clear     (x_clr),
`ifdef STOPWATCH_LAP_EN
        .btn_lap       (x_lap),
`endif
        .digits        (x_digits),
        .running       (x_running),
        .tick          (x_tick),
        .overflow      (x_overflow)
    );

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // Reference model: m_state 0=idle 1=run 2=pause, count as an integer.
    int  m_state, m_count, m_phase, m_hold;
    bit  m_lap_on;
    bit  m_valid = 1'b0;
    bit  lvl [3];
    bit  pls [3];
    bit  hist [3][DB+2];

    always @(posedge clock) begin : model
        bit raw [3];
        bit p_ss, p_clr, p_lap, all_diff;
        int old, nxt, pre;
        raw[0] = b_ss;
        raw[1] = b_clr;
        raw[2] = b_lap;
        if (reset) begin
            m_state = 0; m_count = 0; m_phase = 0; m_hold = 0;
            m_lap_on = 1'b0;
            for (int b = 0; b < 3; b++) begin
                lvl[b] = 1'b0;
                pls[b] = 1'b0;
                for (int k = 0; k < DB + 2; k++) hist[b][k] = 1'b0;
            end
            m_valid = 1'b1;
        end else if (m_valid) begin
            p_ss  = pls[0];
            p_clr = pls[1];
            p_lap = pls[2];
            // A level is accepted once the synchronized input (2 samples
            // old) has disagreed with it for DB consecutive samples.
            for (int b = 0; b < 3; b++) begin
                for (int k = DB + 1; k > 0; k--) hist[b][k] = hist[b][k-1];
                hist[b][0] = raw[b];
                pls[b] = 1'b0;
                all_diff = 1'b1;
                for (int k = 2; k < DB + 2; k++)
                    if (hist[b][k] == lvl[b]) all_diff = 1'b0;
                if (all_diff) begin
                    lvl[b] = !lvl[b];
                    pls[b] = lvl[b];
                end
            end
            old = m_state;
            nxt = old;
            if (old == 0 && p_ss) nxt = 1;
            else if (old == 1 && p_ss) nxt = 2;
            else if (old == 2 && p_clr) nxt = 0;
            else if (old == 2 && p_ss) nxt = 1;
            pre = m_count;
            if (old == 1) begin
                m_phase++;
                if (m_phase == DIV) begin
                    m_phase = 0;
                    m_count = (m_count + 1) % 10000;
                end
            end
            if (nxt == 0) begin
                m_count = 0;
                m_phase = 0;
            end
`ifdef STOPWATCH_LAP_EN
            if (nxt != old) m_lap_on = 1'b0;
            else if (old == 1 && p_lap) begin
                if (m_lap_on) m_lap_on = 1'b0;
                else begin
                    m_lap_on = 1'b1;
                    m_hold = pre;
                end
            end
`else
            if (p_lap && pre < 0) m_hold = pre;
`endif
            m_state = nxt;
        end
    end

    always @(negedge clock) begin : compare
        bit e_tick;
        if (m_valid) begin
            e_tick = (m_state == 1) && (m_phase == DIV - 1);
            chk("m_running", 32'(running), 32'(m_state == 1));
            chk("m_tick", 32'(tick), 32'(e_tick));
            chk("m_overflow", 32'(overflow), 32'(e_tick && m_count == 9999));
            chk("m_digits", 32'(digits),
                32'(to_bcd(m_lap_on ? m_hold : m_count)));
        end
    end

    task automatic press_ss();
        b_ss = 1'b1;
        repeat (DB + 2) @(negedge clock);
        b_ss = 1'b0;
        repeat (DB + 3) @(negedge clock);
    endtask

    task automatic press_clr();
        b_clr = 1'b1;
        repeat (DB + 2) @(negedge clock);
        b_clr = 1'b0;
        repeat (DB + 3) @(negedge clock);
    endtask

    task automatic wait_tick_at(input logic [15:0] d, input string nm);
        int n = 0;
        @(negedge clock);
        while (!(tick && digits == d) && n < 2000) begin
            @(negedge clock);
            n++;
        end
        chk(nm, 32'(n < 2000), 32'd1);
    endtask

    initial begin : stim
        int lat, nt, first, last, bad, seen, ovf;
        repeat (2) @(negedge clock);
        chk("rst_digits", 32'(digits), 32'h0000);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Bounce shorter than the debounce window must never register.
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            b_ss = ~b_ss;
            repeat (2) begin
                @(negedge clock);
                if (running) seen = 1;
            end
        end
        b_ss = 1'b0;
        repeat (DB + 4) begin
            @(negedge clock);
            if (running) seen = 1;
        end
        chk("bounce_idle", 32'(seen), 32'd0);

        b_ss = 1'b1;
        lat = 0;
        while (!running && lat < 20) begin
            @(negedge clock);
            lat++;
            if (lat == DB + 2) b_ss = 1'b0;
        end
        b_ss = 1'b0;
        chk("start_latency", 32'(lat), 32'(DB + 3));
        nt = 0; first = -1; last = -1; bad = 0;
        for (int i = 0; i < 250; i++) begin
            if (tick) begin
                if (first < 0) first = i;
                if (last >= 0 && i - last != DIV) bad++;
                last = i;
                nt++;
            end
            @(negedge clock);
        end
        chk("run_ticks", 32'(nt), 32'd25);
        chk("first_tick", 32'(first), 32'd9);
        chk("tick_spacing", 32'(bad), 32'd0);
        chk("run_digits", 32'(digits), 32'h0025);
        chk("run_running", 32'(running), 32'd1);

        press_ss();
        press_clr();
        chk("clr1_digits", 32'(digits), 32'h0000);
        press_ss();
        wait_tick_at(16'h0012, "wait_0012");
        press_ss();
        chk("pause_running", 32'(running), 32'd0);
        chk("pause_digits", 32'(digits), 32'h0013);
        bad = 0;
        repeat (100) begin
            @(negedge clock);
            if (digits !== 16'h0013 || tick) bad++;
        end
        chk("pause_hold", 32'(bad), 32'd0);
        press_clr();
        chk("clr_digits", 32'(digits), 32'h0000);
        chk("clr_running", 32'(running), 32'd0);

`ifdef STOPWATCH_LAP_EN
        press_ss();
        wait_tick_at(16'h0041, "wait_0041");
        b_lap = 1'b1;
        repeat (DB + 2) @(negedge clock);
        b_lap = 1'b0;
        repeat (2) @(negedge clock);
        chk("lap_frozen", 32'(digits), 32'h0042);
        bad = 0; nt = 0;
        repeat (40) begin
            @(negedge clock);
            if (digits !== 16'h0042) bad++;
            if (tick) nt++;
        end
        chk("lap_hold", 32'(bad), 32'd0);
        chk("lap_ticks", 32'(nt > 0), 32'd1);
        lat = 0;
        while (!(tick && m_count == 49) && lat < 2000) begin
            @(negedge clock);
            lat++;
        end
        b_lap = 1'b1;
        repeat (DB + 2) @(negedge clock);
        b_lap = 1'b0;
        repeat (2) @(negedge clock);
        chk("lap_release", 32'(digits), 32'h0050);
        press_ss();
        press_clr();
`endif

        // Random buttons, including simultaneous presses and resets.
        for (int s = 0; s < 300; s++) begin
            if ($urandom_range(0, 59) == 0) begin
                reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
            end
            if ($urandom_range(0, 4) == 0) begin
                b_ss = 1'b1;
                b_clr = 1'b1;
            end else begin
                b_ss  = ($urandom_range(0, 2) == 0);
                b_clr = ($urandom_range(0, 4) == 0);
            end
            b_lap = ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(1, 14)) @(negedge clock);
        end
        b_ss = 1'b0; b_clr = 1'b0; b_lap = 1'b0;
        repeat (DB + 4) @(negedge clock);

        x_ss = 1'b1;
        repeat (DB + 2) @(negedge clock);
        x_ss = 1'b0;
        lat = 0; ovf = 0;
        while (x_digits !== 16'h9999 && lat < 11000) begin
            if (x_overflow) ovf++;
            @(negedge clock);
            lat++;
        end
        chk("wrap_reached", 32'(lat < 11000), 32'd1);
        chk("wrap_no_early_ovf", 32'(ovf), 32'd0);
        chk("wrap_tick", 32'(x_tick), 32'd1);
        chk("wrap_overflow", 32'(x_overflow), 32'd1);
        @(negedge clock);
        chk("wrap_digits", 32'(x_digits), 32'h0000);
        chk("wrap_ovf_once", 32'(x_overflow), 32'd0);
        chk("wrap_running", 32'(x_running), 32'd1);
        @(negedge clock);
        chk("wrap_next", 32'(x_digits), 32'h0001);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
